// File: rtl/approx_err_monitor_pkg.sv
// Shared types and defaults for the approximate-multiplier error monitor.
// Holds the FSM state encoding and default widths.
package approx_err_monitor_pkg;

  localparam int PW_D    = 16;
  localparam int CNT_W_D = 17;
  localparam int ACC_W_D = 33;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/approx_err_monitor_if.sv
// Control, sample-stream and statistics bundle of the error monitor.
// master: stimulus side; slave: the monitor.
interface approx_err_monitor_if
  import approx_err_monitor_pkg::*;
#(
  parameter int PW    = PW_D,
  parameter int CNT_W = CNT_W_D,
  parameter int ACC_W = ACC_W_D
) ();

  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    approx_prod;
  logic [PW-1:0]    exact_prod;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] sum_ed;
  logic [PW-1:0]    max_ed;

  modport master (
    output start, num_samples, in_valid,
    output approx_prod, exact_prod,
    input  in_ready, busy, done,
    input  err_count, sum_ed, max_ed
  );

  modport slave (
    input  start, num_samples, in_valid,
    input  approx_prod, exact_prod,
    output in_ready, busy, done,
    output err_count, sum_ed, max_ed
  );

endinterface

// File: rtl/approx_err_monitor_abs_diff.sv
// Combinational |a - b| over PW-bit unsigned operands.
// Ports: i_a, i_b operands; o_abs PW-bit magnitude.
module abs_diff #(
  parameter int PW = 16
) (
  input  logic [PW-1:0] i_a,
  input  logic [PW-1:0] i_b,
  output logic [PW-1:0] o_abs
);

  logic signed [PW:0] w_diff;

  assign w_diff = $signed({1'b0, i_a})
                - $signed({1'b0, i_b});

  // |diff| never exceeds 2^PW-1, so PW bits suffice
  assign o_abs = w_diff[PW] ? PW'(-w_diff)
                            : PW'(w_diff);

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error statistics (count, sum ED, max ED) for approx multipliers.
// Ports: clk, rst_n (async active-low), bus (slave modport of the bundle).
module approx_err_monitor
  import approx_err_monitor_pkg::*;
#(
  parameter int PW    = PW_D,
  parameter int CNT_W = CNT_W_D,
  parameter int ACC_W = ACC_W_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_err_monitor_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [ACC_W-1:0] SUM_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_acc;
  logic             r_s1_valid;
  logic             r_s1_neq;
  logic [PW-1:0]    r_s1_ed;
  logic [CNT_W-1:0] r_err;
  logic [ACC_W-1:0] r_sum;
  logic [PW-1:0]    r_max;

  logic             w_ready;
  logic             w_hs;
  logic             w_start_ok;
  logic             w_last;
  logic [PW-1:0]    w_ed;
  logic [ACC_W:0]   w_sum_ext;

  abs_diff #(.PW(PW)) u_abs (
    .i_a   (bus.approx_prod),
    .i_b   (bus.exact_prod),
    .o_abs (w_ed)
  );

  assign w_ready    = (r_state == S_RUN) &&
                      (r_acc < r_n);
  assign w_hs       = bus.in_valid & w_ready;
  assign w_start_ok = (r_state == S_IDLE) &
                      bus.start;
  assign w_last     = w_hs &&
                      ((r_acc + CNT_ONE) == r_n);
  assign w_sum_ext  = {1'b0, r_sum} +
                      {{(ACC_W+1-PW){1'b0}}, r_s1_ed};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_state_nxt = (bus.num_samples != '0)
                      ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // window length and accepted-sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n   <= '0;
      r_acc <= '0;
    end else if (w_start_ok) begin
      r_n   <= bus.num_samples;
      r_acc <= '0;
    end else if (w_hs) begin
      r_acc <= r_acc + CNT_ONE;
    end
  end

  // stage 1: capture ED only on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_neq   <= 1'b0;
      r_s1_ed    <= '0;
    end else begin
      r_s1_valid <= w_hs;
      if (w_hs) begin
        r_s1_neq <= (bus.approx_prod !=
                     bus.exact_prod);
        r_s1_ed  <= w_ed;
      end
    end
  end

  // stage 2: accumulate; stage 1 is empty in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
      r_sum <= '0;
      r_max <= '0;
    end else if (w_start_ok) begin
      r_err <= '0;
      r_sum <= '0;
      r_max <= '0;
    end else if (r_s1_valid) begin
      if (r_s1_neq) r_err <= r_err + CNT_ONE;
      r_sum <= w_sum_ext[ACC_W] ? SUM_MAX
                                : w_sum_ext[ACC_W-1:0];
      if (r_s1_ed > r_max) r_max <= r_s1_ed;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.busy      = (r_state == S_RUN) ||
                         (r_state == S_DRAIN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err_count = r_err;
  assign bus.sum_ed    = r_sum;
  assign bus.max_ed    = r_max;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Self-checking bench for approx_err_monitor.
// Expected window statistics are queued at stimulus and popped at done.
module tb_approx_err_monitor;
  import approx_err_monitor_pkg::*;

  localparam int PW    = 16;
  localparam int CNT_W = 17;
  localparam int ACC_W = 33;

  typedef struct packed {
    logic [CNT_W-1:0] err;
    logic [ACC_W-1:0] sum;
    logic [PW-1:0]    mx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  approx_err_monitor_if #(
    .PW(PW), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) bus ();

  approx_err_monitor #(
    .PW(PW), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.approx_prod = PW'($urandom);
    bus.exact_prod  = PW'($urandom);
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_samples = n[CNT_W-1:0];
    @(negedge clk);
    bus.start       = 1'b0;
    bus.num_samples = CNT_W'($urandom);
  endtask

  // present one sample; returns on the negedge after its handshake
  task automatic send(input logic [PW-1:0] a,
                      input logic [PW-1:0] e);
    int k;
    k = 0;
    bus.in_valid    = 1'b1;
    bus.approx_prod = a;
    bus.exact_prod  = e;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k == 20) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1",
               bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({bus.in_ready, bus.busy, bus.done} !== 3'b000 ||
        bus.err_count !== '0 || bus.sum_ed !== '0 ||
        bus.max_ed !== '0) begin
      errors++;
      $display("FAIL reset_init: rdy=%b busy=%b done=%b err=%0d sum=%0d max=%0d required all 0",
               bus.in_ready, bus.busy, bus.done,
               bus.err_count, bus.sum_ed, bus.max_ed);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(5);
    send(16'd9, 16'd1);
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.err_count !== 17'd1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: err=%0d busy=%b required 1 1",
               bus.err_count, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.done} !== 3'b000 ||
        bus.err_count !== '0 || bus.sum_ed !== '0 ||
        bus.max_ed !== '0) begin
      errors++;
      $display("FAIL reset_async: rdy=%b busy=%b done=%b err=%0d sum=%0d max=%0d required all 0",
               bus.in_ready, bus.busy, bus.done,
               bus.err_count, bus.sum_ed, bus.max_ed);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    do_start(3);
    sb.push_back('{err: 17'd2, sum: 33'd12, mx: 16'd10});
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_run: busy=%b rdy=%b required 1 1",
               bus.busy, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.approx_prod = 16'd100; bus.exact_prod = 16'd100;
    @(negedge clk);
    bus.approx_prod = 16'd198; bus.exact_prod = 16'd200;
    @(negedge clk);
    bus.approx_prod = 16'd60;  bus.exact_prod = 16'd50;
    @(negedge clk);
    // valid held with junk: must be ignored while not ready
    bus.approx_prod = 16'd0;   bus.exact_prod = 16'd999;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
        bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: rdy=%b busy=%b done=%b required 0 1 0",
               bus.in_ready, bus.busy, bus.done);
    end
    @(negedge clk);
    pop_exp(e);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b required 1 0",
               bus.done, bus.busy);
    end
    checks++;
    if ({bus.err_count, bus.sum_ed, bus.max_ed} !== e) begin
      errors++;
      $display("FAIL basic_stats: err=%0d sum=%0d max=%0d required %0d %0d %0d",
               bus.err_count, bus.sum_ed, bus.max_ed,
               e.err, e.sum, e.mx);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
        {bus.err_count, bus.sum_ed, bus.max_ed} !== e) begin
      errors++;
      $display("FAIL basic_hold: done=%b busy=%b err=%0d sum=%0d max=%0d required 0 0 %0d %0d %0d",
               bus.done, bus.busy, bus.err_count,
               bus.sum_ed, bus.max_ed, e.err, e.sum, e.mx);
    end
    idle_inputs();
  endtask

  task automatic test_gaps();
    exp_t e;
    bit ok;
    do_start(2);
    sb.push_back('{err: 17'd2, sum: 33'd130050,
                   mx: 16'd65025});
    send(16'd0, 16'd65025);
    idle_inputs();
    repeat (3) begin
      @(negedge clk);
      idle_inputs();
    end
    send(16'd65025, 16'd0);
    idle_inputs();
    wait_done(ok);
    pop_exp(e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gaps_timeout: done=%b required 1", bus.done);
    end
    checks++;
    if ({bus.err_count, bus.sum_ed, bus.max_ed} !== e) begin
      errors++;
      $display("FAIL gaps_stats: err=%0d sum=%0d max=%0d required %0d %0d %0d",
               bus.err_count, bus.sum_ed, bus.max_ed,
               e.err, e.sum, e.mx);
    end
  endtask

  task automatic test_zero();
    exp_t e;
    @(negedge clk);
    do_start(0);
    sb.push_back('0);
    pop_exp(e);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 ||
        {bus.err_count, bus.sum_ed, bus.max_ed} !== e) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b err=%0d sum=%0d max=%0d required 1 0 0 0 0",
               bus.done, bus.busy, bus.err_count,
               bus.sum_ed, bus.max_ed);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: done=%b busy=%b required 0 0",
               bus.done, bus.busy);
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    bit ok;
    do_start(4);
    sb.push_back('{err: 17'd3, sum: 33'd28, mx: 16'd20});
    send(16'd10, 16'd3);
    send(16'd5, 16'd5);
    idle_inputs();
    bus.start = 1'b1;
    bus.num_samples = 17'd1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 ||
        bus.err_count !== 17'd1 || bus.sum_ed !== 33'd7) begin
      errors++;
      $display("FAIL restart_ignored: busy=%b rdy=%b err=%0d sum=%0d required 1 1 1 7",
               bus.busy, bus.in_ready,
               bus.err_count, bus.sum_ed);
    end
    send(16'd0, 16'd20);
    send(16'd9, 16'd8);
    idle_inputs();
    wait_done(ok);
    pop_exp(e);
    checks++;
    if (!ok || {bus.err_count, bus.sum_ed, bus.max_ed} !== e) begin
      errors++;
      $display("FAIL restart_stats: done=%b err=%0d sum=%0d max=%0d required 1 %0d %0d %0d",
               bus.done, bus.err_count, bus.sum_ed,
               bus.max_ed, e.err, e.sum, e.mx);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    bit ok;
    do_start(10);
    for (int i = 0; i < 5; i++)
      send(PW'(i * 3 + 1), 16'd0);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.done} !== 3'b000 ||
        bus.err_count !== '0 || bus.sum_ed !== '0 ||
        bus.max_ed !== '0) begin
      errors++;
      $display("FAIL abort_reset: rdy=%b busy=%b done=%b err=%0d sum=%0d max=%0d required all 0",
               bus.in_ready, bus.busy, bus.done,
               bus.err_count, bus.sum_ed, bus.max_ed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1);
    sb.push_back('{err: 17'd1, sum: 33'd4, mx: 16'd4});
    send(16'd7, 16'd3);
    idle_inputs();
    wait_done(ok);
    pop_exp(e);
    checks++;
    if (!ok || {bus.err_count, bus.sum_ed, bus.max_ed} !== e) begin
      errors++;
      $display("FAIL abort_stats: done=%b err=%0d sum=%0d max=%0d required 1 %0d %0d %0d",
               bus.done, bus.err_count, bus.sum_ed,
               bus.max_ed, e.err, e.sum, e.mx);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_samples = '0;
    idle_inputs();
    test_reset();
    test_basic();
    test_gaps();
    test_zero();
    test_start_ignored();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
